// File: rtl/xbar_pkt_scheduler_pkg.sv
// Shared constants, FSM state type and width helper for the packet crossbar scheduler.
package xbar_pkt_scheduler_pkg;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Width of an index into n items; never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/xbar_pkt_scheduler_arbiter.sv
// Per-master arbiter: picks one requesting source, then holds it until the packet's
// last beat (or a watchdog release) so packets never interleave on this master.
module xbar_pkt_arbiter
  import xbar_pkt_scheduler_pkg::*;
#(
  parameter int S_DATA_COUNT  = 5,
  parameter int ID_WIDTH      = 3,
  parameter int ARB_MODE      = ARB_RR,
  parameter int MAX_PKT_BEATS = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [S_DATA_COUNT-1:0] req_i,
  input  logic [S_DATA_COUNT-1:0] s_valid_i,
  input  logic [S_DATA_COUNT-1:0] s_last_i,
  input  logic                    m_ready_i,
  output logic [S_DATA_COUNT-1:0] grant_o,
  output logic [ID_WIDTH-1:0]     id_o,
  output logic                    busy_o,
  output logic                    m_valid_o,
  output logic                    m_last_o,
  output logic [S_DATA_COUNT-1:0] s_ready_o,
  output logic                    timeout_o
);

  localparam int  CW      = ID_WIDTH + 1;
  localparam int  CNTW    = clog2_min1(MAX_PKT_BEATS + 1);
  localparam bit  WDOG_EN = (MAX_PKT_BEATS > 0);
  localparam logic [CNTW-1:0] CNT_LAST = WDOG_EN ? CNTW'(MAX_PKT_BEATS - 1) : '0;

  arb_state_e              state_q;
  logic [ID_WIDTH-1:0]     ptr_q;
  logic [CNTW-1:0]         cnt_q;
  logic [S_DATA_COUNT-1:0] grant_q;
  logic [ID_WIDTH-1:0]     id_q;
  logic                    timeout_q;

  logic                    win_found;
  logic [ID_WIDTH-1:0]     win_idx;
  logic [CW-1:0]           cand;
  logic [ID_WIDTH-1:0]     ptr_d;
  logic                    beat;
  logic                    beat_last;

  // Rotating search from ptr_q in round-robin mode, plain index order otherwise.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < S_DATA_COUNT; k++) begin
      if (ARB_MODE == ARB_FIXED) begin
        cand = CW'(k);
      end else begin
        cand = {1'b0, ptr_q} + CW'(k);
        if (cand >= CW'(S_DATA_COUNT)) cand = cand - CW'(S_DATA_COUNT);
      end
      if (!win_found && req_i[cand[ID_WIDTH-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[ID_WIDTH-1:0];
      end
    end
  end

  assign ptr_d     = (win_idx == ID_WIDTH'(S_DATA_COUNT - 1)) ? '0 : win_idx + ID_WIDTH'(1);
  assign m_valid_o = (state_q == LOCKED) & s_valid_i[id_q];
  assign m_last_o  = (state_q == LOCKED) & s_last_i[id_q];
  assign beat      = m_valid_o & m_ready_i;
  assign beat_last = beat & m_last_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      grant_q   <= '0;
      id_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_found) begin
            state_q <= LOCKED;
            grant_q <= S_DATA_COUNT'(1) << win_idx;
            id_q    <= win_idx;
            cnt_q   <= '0;
            if (ARB_MODE == ARB_RR) ptr_q <= ptr_d;
          end
        end
        LOCKED: begin
          if (beat_last || (beat && WDOG_EN && cnt_q == CNT_LAST)) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            id_q      <= '0;
            cnt_q     <= '0;
            timeout_q <= !beat_last;
          end else if (beat) begin
            cnt_q <= cnt_q + CNTW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant_o   = grant_q;
  assign id_o      = id_q;
  assign busy_o    = (state_q == LOCKED);
  assign s_ready_o = grant_q & {S_DATA_COUNT{m_ready_i}};
  assign timeout_o = timeout_q;

endmodule

// File: rtl/xbar_pkt_scheduler.sv
// Packet-aware crossbar scheduler: one locking arbiter per master, plus ready/valid
// steering. A beat moves on master j when m_valid_o[j] & m_ready_i[j]; the granted
// source sees s_ready_o = m_ready_i[j] combinationally, ungranted sources see 0.
module xbar_pkt_scheduler
  import xbar_pkt_scheduler_pkg::*;
#(
  parameter int S_DATA_COUNT  = 5,
  parameter int M_DATA_COUNT  = 3,
  parameter int T_ID___WIDTH  = clog2_min1(S_DATA_COUNT),
  parameter int T_DEST_WIDTH  = clog2_min1(M_DATA_COUNT),
  parameter int ARB_MODE      = ARB_RR,
  parameter int MAX_PKT_BEATS = 0
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [S_DATA_COUNT*T_DEST_WIDTH-1:0] s_dest_i,
  input  logic [S_DATA_COUNT-1:0]              s_valid_i,
  input  logic [S_DATA_COUNT-1:0]              s_last_i,
  input  logic [M_DATA_COUNT-1:0]              m_ready_i,
  output logic [S_DATA_COUNT-1:0]              s_ready_o,
  output logic [M_DATA_COUNT-1:0]              m_valid_o,
  output logic [M_DATA_COUNT-1:0]              m_last_o,
  output logic [M_DATA_COUNT*T_ID___WIDTH-1:0] m_id_o,
  output logic [M_DATA_COUNT*S_DATA_COUNT-1:0] grant_o,
  output logic [M_DATA_COUNT-1:0]              m_busy_o,
  output logic [M_DATA_COUNT-1:0]              pkt_timeout_o
);

  logic [S_DATA_COUNT-1:0] sready_m [M_DATA_COUNT];

  for (genvar j = 0; j < M_DATA_COUNT; j++) begin : g_master
    logic [S_DATA_COUNT-1:0] req;

    // Out-of-range destinations match no master, so such sources simply stall.
    for (genvar i = 0; i < S_DATA_COUNT; i++) begin : g_req
      assign req[i] = s_valid_i[i] &
                      (s_dest_i[i*T_DEST_WIDTH +: T_DEST_WIDTH] == T_DEST_WIDTH'(j));
    end

    xbar_pkt_arbiter #(
      .S_DATA_COUNT (S_DATA_COUNT),
      .ID_WIDTH     (T_ID___WIDTH),
      .ARB_MODE     (ARB_MODE),
      .MAX_PKT_BEATS(MAX_PKT_BEATS)
    ) u_arb (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_i    (req),
      .s_valid_i(s_valid_i),
      .s_last_i (s_last_i),
      .m_ready_i(m_ready_i[j]),
      .grant_o  (grant_o[j*S_DATA_COUNT +: S_DATA_COUNT]),
      .id_o     (m_id_o[j*T_ID___WIDTH +: T_ID___WIDTH]),
      .busy_o   (m_busy_o[j]),
      .m_valid_o(m_valid_o[j]),
      .m_last_o (m_last_o[j]),
      .s_ready_o(sready_m[j]),
      .timeout_o(pkt_timeout_o[j])
    );
  end

  always_comb begin
    s_ready_o = '0;
    for (int j = 0; j < M_DATA_COUNT; j++) s_ready_o = s_ready_o | sready_m[j];
  end

endmodule

// File: tb/tb_xbar_pkt_scheduler.sv
// Bench for xbar_pkt_scheduler: a round-robin/watchdog instance and a fixed-priority
// instance share one stimulus stream; each is scored against a packet-level model.
module tb_xbar_pkt_scheduler;

  localparam int S  = 5;
  localparam int M  = 3;
  localparam int IDW = 3;
  localparam int DW  = 2;

  typedef struct packed {
    logic [S-1:0]     s_ready;
    logic [M-1:0]     m_valid;
    logic [M-1:0]     m_last;
    logic [M*IDW-1:0] m_id;
    logic [M*S-1:0]   grant;
    logic [M-1:0]     busy;
    logic [M-1:0]     tmo;
  } obs_t;
  localparam int OBS_W = $bits(obs_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [S*DW-1:0] s_dest;
  logic [S-1:0]    s_valid, s_last;
  logic [M-1:0]    m_ready;

  logic [S-1:0] rr_s_ready, fp_s_ready;
  logic [M-1:0] rr_m_valid, fp_m_valid, rr_m_last, fp_m_last;
  logic [M*IDW-1:0] rr_m_id, fp_m_id;
  logic [M*S-1:0]   rr_grant, fp_grant;
  logic [M-1:0] rr_busy, fp_busy, rr_tmo, fp_tmo;

  xbar_pkt_scheduler #(.S_DATA_COUNT(S), .M_DATA_COUNT(M), .ARB_MODE(0), .MAX_PKT_BEATS(4)) dut_rr (
    .clk(clk), .rst_n(rst_n), .s_dest_i(s_dest), .s_valid_i(s_valid), .s_last_i(s_last),
    .m_ready_i(m_ready), .s_ready_o(rr_s_ready), .m_valid_o(rr_m_valid), .m_last_o(rr_m_last),
    .m_id_o(rr_m_id), .grant_o(rr_grant), .m_busy_o(rr_busy), .pkt_timeout_o(rr_tmo));

  xbar_pkt_scheduler #(.S_DATA_COUNT(S), .M_DATA_COUNT(M), .ARB_MODE(1), .MAX_PKT_BEATS(0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .s_dest_i(s_dest), .s_valid_i(s_valid), .s_last_i(s_last),
    .m_ready_i(m_ready), .s_ready_o(fp_s_ready), .m_valid_o(fp_m_valid), .m_last_o(fp_m_last),
    .m_id_o(fp_m_id), .grant_o(fp_grant), .m_busy_o(fp_busy), .pkt_timeout_o(fp_tmo));

  obs_t act_rr, act_fp;
  assign act_rr = {rr_s_ready, rr_m_valid, rr_m_last, rr_m_id, rr_grant, rr_busy, rr_tmo};
  assign act_fp = {fp_s_ready, fp_m_valid, fp_m_last, fp_m_id, fp_grant, fp_busy, fp_tmo};

  // ---------------- reference model (index 0 = rr/watchdog 4, 1 = fixed/no watchdog) ----------------
  int owner [2][M];   // source holding master j, -1 when free
  int ptr   [2][M];
  int cnt   [2][M];
  bit tmo   [2][M];

  function automatic int dest_of(input int i);
    return int'(s_dest[i*DW +: DW]);
  endfunction

  function automatic bit owned_any(input int i);
    for (int d = 0; d < 2; d++)
      for (int j = 0; j < M; j++)
        if (owner[d][j] == i) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int j = 0; j < M; j++) begin
        owner[d][j] = -1; ptr[d][j] = 0; cnt[d][j] = 0; tmo[d][j] = 1'b0;
      end
  endtask

  // One clock of the packet rules: free masters pick a requester, held masters count beats.
  task automatic model_step(input int d);
    int i, g, maxb;
    maxb = (d == 0) ? 4 : 0;
    for (int j = 0; j < M; j++) begin
      tmo[d][j] = 1'b0;
      if (owner[d][j] < 0) begin
        for (int k = 0; k < S; k++) begin
          i = (d == 1) ? k : (ptr[d][j] + k) % S;
          if (owner[d][j] < 0 && s_valid[i] && dest_of(i) == j) begin
            owner[d][j] = i;
            cnt[d][j]   = 0;
            if (d == 0) ptr[d][j] = (i + 1) % S;
          end
        end
      end else begin
        g = owner[d][j];
        if (s_valid[g] && m_ready[j]) begin
          cnt[d][j]++;
          if (s_last[g]) begin
            owner[d][j] = -1; cnt[d][j] = 0;
          end else if (maxb > 0 && cnt[d][j] == maxb) begin
            owner[d][j] = -1; cnt[d][j] = 0; tmo[d][j] = 1'b1;
          end
        end
      end
    end
  endtask

  function automatic obs_t model_obs(input int d);
    obs_t o;
    int g;
    o = '0;
    for (int j = 0; j < M; j++) begin
      o.tmo[j] = tmo[d][j];
      if (owner[d][j] >= 0) begin
        g = owner[d][j];
        o.busy[j]             = 1'b1;
        o.grant[j*S + g]      = 1'b1;
        o.m_id[j*IDW +: IDW]  = IDW'(g);
        o.m_valid[j]          = s_valid[g];
        o.m_last[j]           = s_last[g];
        if (m_ready[j]) o.s_ready[g] = 1'b1;
      end
    end
    return o;
  endfunction

  // ---------------- scoreboard ----------------
  logic [OBS_W-1:0] exp_q_rr[$];
  logic [OBS_W-1:0] exp_q_fp[$];
  int errors = 0;
  int checks = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic compare_obs(input string tag, input obs_t exp, input obs_t act);
    cmp({tag, " s_ready_o"},     32'(act.s_ready), 32'(exp.s_ready));
    cmp({tag, " m_valid_o"},     32'(act.m_valid), 32'(exp.m_valid));
    cmp({tag, " m_last_o"},      32'(act.m_last),  32'(exp.m_last));
    cmp({tag, " m_id_o"},        32'(act.m_id),    32'(exp.m_id));
    cmp({tag, " grant_o"},       32'(act.grant),   32'(exp.grant));
    cmp({tag, " m_busy_o"},      32'(act.busy),    32'(exp.busy));
    cmp({tag, " pkt_timeout_o"}, 32'(act.tmo),     32'(exp.tmo));
  endtask

  always @(negedge clk) begin
    if (exp_q_rr.size() > 0) compare_obs("rr", obs_t'(exp_q_rr.pop_front()), act_rr);
    if (exp_q_fp.size() > 0) compare_obs("fp", obs_t'(exp_q_fp.pop_front()), act_fp);
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic [S-1:0] v, input logic [S-1:0] l,
                      input logic [S*DW-1:0] dst, input logic [M-1:0] r);
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    s_valid = v; s_last = l; s_dest = dst; m_ready = r;
    exp_q_rr.push_back(model_obs(0));
    exp_q_fp.push_back(model_obs(1));
  endtask

  task automatic mid_reset(input bit keep);
    @(posedge clk);
    #2;
    if (keep) begin s_valid = '1; s_last = '1; s_dest = '0; end
    rst_n = 1'b0;
    #1;
    compare_obs("async_rst_rr", '0, act_rr);
    compare_obs("async_rst_fp", '0, act_fp);
    model_reset();
    @(negedge clk);
    #1;
    if (!keep) begin s_valid = '0; s_last = '0; end
    rst_n = 1'b1;
  endtask

  function automatic logic [S*DW-1:0] pack_dest(input int d0, input int d1, input int d2,
                                                input int d3, input int d4);
    return {DW'(d4), DW'(d3), DW'(d2), DW'(d1), DW'(d0)};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [S*DW-1:0] nd;
    logic [S-1:0]    v, l;
    logic [M-1:0]    r;

    rst_n = 1'b0; s_valid = '1; s_last = '1; s_dest = '0; m_ready = 3'b111;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_obs("reset_rr", '0, act_rr);
    compare_obs("reset_fp", '0, act_fp);
    @(negedge clk); #1; rst_n = 1'b1;
    repeat (10) step('1, '1, '0, 3'b111);

    // Round-robin rotation among s0/s2/s4 onto m1.
    mid_reset(1'b0);
    repeat (10) step(5'b10101, 5'b10101, pack_dest(1, 0, 1, 0, 1), 3'b111);

    // s1 and s3 both target m0; s1's packet must finish before s3 moves.
    mid_reset(1'b0);
    repeat (4) step(5'b01010, 5'b00000, '0, 3'b111);
    step(5'b01010, 5'b00010, '0, 3'b111);
    repeat (6) step(5'b01000, 5'b01000, '0, 3'b111);

    // Backpressure on m2 mid-packet.
    mid_reset(1'b0);
    repeat (2) step(5'b00100, 5'b00000, pack_dest(0, 0, 2, 0, 0), 3'b111);
    repeat (3) step(5'b00100, 5'b00000, pack_dest(0, 0, 2, 0, 0), 3'b011);
    step(5'b00100, 5'b00000, pack_dest(0, 0, 2, 0, 0), 3'b111);
    step(5'b00100, 5'b00100, pack_dest(0, 0, 2, 0, 0), 3'b111);
    repeat (2) step(5'b00000, 5'b00000, pack_dest(0, 0, 2, 0, 0), 3'b111);

    // s0 and s2 contend for m2 while s4 points at a master that does not exist.
    mid_reset(1'b0);
    repeat (8) step(5'b10101, 5'b10101, pack_dest(2, 0, 2, 0, 3), 3'b111);

    // Endless packet from s2: forced release after four beats on the watchdog instance.
    mid_reset(1'b0);
    repeat (12) step(5'b00100, 5'b00000, pack_dest(0, 0, 2, 0, 0), 3'b111);

    // Random traffic; a source only retargets while no master holds it.
    mid_reset(1'b0);
    for (int c = 0; c < 1500; c++) begin
      nd = s_dest;
      for (int i = 0; i < S; i++) begin
        if (!owned_any(i) && $urandom_range(0, 7) == 0) nd[i*DW +: DW] = DW'($urandom_range(0, 3));
        v[i] = ($urandom_range(0, 3) != 0);
        l[i] = ($urandom_range(0, 2) == 0);
      end
      for (int j = 0; j < M; j++) r[j] = ($urandom_range(0, 3) != 0);
      step(v, l, nd, r);
      if (c == 700) mid_reset(1'b1);
    end

    repeat (3) step('0, '0, s_dest, 3'b111);
    repeat (2) @(negedge clk);
    #1;
    cmp("rr queue drained", 32'(exp_q_rr.size()), 32'd0);
    cmp("fp queue drained", 32'(exp_q_fp.size()), 32'd0);

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
